// File: rtl/fifo_burst_drain.sv
// -----------------------------------------------------------------------------
// fifo_burst_drain
//
// Downstream stage of the 64x8 watermark FIFO. While the FIFO's low-watermark
// flag is clear, it reads the FIFO in fixed bursts of BURST_LEN words. Each
// word is captured one cycle after its read strobe and pushed into a small
// circular buffer. The buffer is presented on a valid/ready stream, and the
// final beat of every burst is tagged with m_last.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset (shared with the FIFO)
//   fifo_empty  in   FIFO low-watermark flag (1 when FIFO count < 16)
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  FIFO read strobe (registered)
//   m_data      out  stream data (head of buffer, 0 when empty)
//   m_last      out  stream last-beat-of-burst flag
//   m_valid     out  stream valid (buffer not empty)
//   m_ready     in   stream ready from consumer
//   busy        out  burst active or any beat in flight / buffered
//
// Optional build macro FIFO_BURST_DRAIN_STAT_EN adds:
//   burst_cnt   out  saturating count of bursts started
//   stall_cnt   out  saturating count of cycles with m_valid && !m_ready
//
// Parameter constraints: BUF_DEPTH is a power of 2 and at least 2, and
// BUF_DEPTH >= BURST_LEN. BURST_LEN <= 16 so that one burst never underruns
// the FIFO.
// -----------------------------------------------------------------------------
module fifo_burst_drain #(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 8,
   parameter int BUF_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy
`ifdef FIFO_BURST_DRAIN_STAT_EN
   ,
   output logic [15:0]      burst_cnt,
   output logic [15:0]      stall_cnt
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int OW = $clog2(BUF_DEPTH) + 1;
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [OW-1:0] OCC_LIMIT = OW'(BUF_DEPTH - BURST_LEN);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state_q, state_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             rd_en_q, rd_en_d;
   logic             pend_q;
   logic             pend_last_q;
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [OW-1:0]    cnt_q;
   logic [OW-1:0]    occ_q, occ_d;
   logic [OW-1:0]    occ_after_pop;
   logic [WIDTH:0]   mem_q [BUF_DEPTH];
   logic             push, pop;

   assign push = pend_q;
   assign pop  = m_valid && m_ready;

   // occ counts buffered entries plus reads still in flight.
   // The start-of-burst check sees this cycle's pop so that a slot being
   // freed right now already counts as free space.
   always_comb begin
      occ_after_pop = pop ? occ_q - OW'(1) : occ_q;
      occ_d         = occ_q;
      unique case ({rd_en_q, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         rd_en_q     <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         rd_en_q     <= rd_en_d;
         pend_q      <= rd_en_q;
         pend_last_q <= rd_en_q && (beat_q == BEAT_LAST);
         occ_q       <= occ_d;
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + OW'(1);
            2'b01:   cnt_q <= cnt_q - OW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Buffer storage is not reset. The pointers and count are reset, and the
   // outputs are gated with m_valid, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wptr_q] <= {pend_last_q, fifo_dout};
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && (occ_after_pop <= OCC_LIMIT)) state_d = BURST;
         end
         BURST: begin
            // fifo_empty is ignored here. Qualification at the start of the
            // burst already guarantees enough words for the whole burst.
            if (beat_q == BEAT_LAST) begin
               state_d = IDLE;
               beat_d  = '0;
            end else begin
               beat_d  = beat_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      rd_en_d    = (state_d == BURST);
      fifo_rd_en = rd_en_q;
      m_valid    = (cnt_q != '0);
      m_data     = m_valid ? mem_q[rptr_q][WIDTH-1:0] : '0;
      m_last     = m_valid ? mem_q[rptr_q][WIDTH]     : 1'b0;
      busy       = (state_q == BURST) || (occ_q != '0);
   end

`ifdef FIFO_BURST_DRAIN_STAT_EN
   logic [15:0] burst_cnt_q;
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if ((state_q == IDLE) && (state_d == BURST) && (burst_cnt_q != '1))
            burst_cnt_q <= burst_cnt_q + 16'd1;
         if (m_valid && !m_ready && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign burst_cnt = burst_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
